// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states, default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ALU_WIDTH - default operand/result width
//   op_e      - 4-bit operation codes (code 4'hF is left undefined)
//   state_t   - controller states IDLE / BUSY / DONE
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_NEG   = 4'h6,
        OP_SLL   = 4'h7,
        OP_SRL   = 4'h8,
        OP_SRA   = 4'h9,
        OP_SLT   = 4'hA,
        OP_SLTU  = 4'hB,
        OP_CMP   = 4'hC,
        OP_MULTU = 4'hD,
        OP_DIVU  = 4'hE
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: start edge loads operands, then exactly WIDTH step edges; done is high during the last step.
// Backpressure: none; the caller must hold off start while an operation is running.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset (aborts any running op)
//   start, is_div - load a/b and begin; is_div selects divide, else multiply
//   a, b          - operands (multiplicand/multiplier or dividend/divisor)
//   done          - this edge completes the op; lo/hi carry the final result
//   lo, hi        - product low/high halves, or quotient/remainder
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic             busy;
    logic             div_mode;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc;      // product high part, or partial remainder
    logic [WIDTH-1:0] sh;       // multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sh_nxt;

    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, (sh[0] ? opb : '0)};
        div_shift = {acc, sh[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        acc_nxt   = acc;
        sh_nxt    = sh;
        if (div_mode) begin
            // Partial remainder is always < divisor, so the MSB of the
            // difference is a clean borrow flag (restore when set).
            if (!div_diff[WIDTH]) begin
                acc_nxt = div_diff[WIDTH-1:0];
                sh_nxt  = {sh[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = div_shift[WIDTH-1:0];
                sh_nxt  = {sh[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift {carry, acc, sh} right by one after the conditional add.
            acc_nxt = mul_sum[WIDTH:1];
            sh_nxt  = {mul_sum[0], sh[WIDTH-1:1]};
        end
    end

    assign done = busy && (cnt == SHW'(WIDTH - 1));
    assign lo   = sh_nxt;
    assign hi   = acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            sh       <= '0;
            opb      <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            cnt      <= '0;
            acc      <= '0;
            sh       <= a;
            opb      <= b;
        end else if (busy) begin
            acc <= acc_nxt;
            sh  <= sh_nxt;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops plus iterative MULTU/DIVU, one op in flight.
// Latency: 1 cycle for single-cycle ops and DIVU by zero; WIDTH+1 cycles for MULTU/DIVU.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operation offer / accept (op, a, b captured on accept)
//   op, a, b            - operation code and operands
//   out_valid, out_ready- result held / consumed
//   res, res_hi         - primary result; product high half or remainder
//   t_written, t        - T-flag update strobe and flag value (SLT/SLTU/CMP)
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             t_written,
    output logic             t
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

    state_t           state;
    state_t           state_nxt;
    op_e              opc;
    logic             load;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_t;
    logic             sc_tw;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_hi_d;
    logic             t_d;
    logic             tw_d;
    logic             shift_big;
    logic [SHW-1:0]   shamt;

    assign opc       = op_e'(op);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign shift_big = (b >= WIDTH_V);
    assign shamt     = b[SHW-1:0];

    // Single-cycle results straight from the live inputs; they are only
    // registered on the accept edge, which is when op/a/b are captured.
    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_t   = 1'b0;
        sc_tw  = 1'b0;
        unique case (opc)
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOT:  sc_res = ~a;
            OP_NEG:  sc_res = '0 - b;
            OP_SLL:  sc_res = shift_big ? '0 : (a << shamt);
            OP_SRL:  sc_res = shift_big ? '0 : (a >> shamt);
            OP_SRA:  sc_res = shift_big ? {WIDTH{a[WIDTH-1]}}
                                        : WIDTH'($signed(a) >>> shamt);
            OP_SLT:  begin sc_tw = 1'b1; sc_t = ($signed(a) < $signed(b)); end
            OP_SLTU: begin sc_tw = 1'b1; sc_t = (a < b); end
            OP_CMP:  begin sc_tw = 1'b1; sc_t = (a != b); end
            // Only reached with b == 0; a nonzero divisor goes iterative.
            OP_DIVU: begin sc_res = '1; sc_hi = a; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        md_start  = 1'b0;
        res_d     = sc_res;
        res_hi_d  = sc_hi;
        t_d       = sc_t;
        tw_d      = sc_tw;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (opc == OP_MULTU || (opc == OP_DIVU && b != '0)) begin
                        md_start  = 1'b1;
                        state_nxt = ST_BUSY;
                    end else begin
                        load      = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                res_d    = md_lo;
                res_hi_d = md_hi;
                t_d      = 1'b0;
                tw_d     = 1'b0;
                if (md_done) begin
                    load      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            res       <= '0;
            res_hi    <= '0;
            t         <= 1'b0;
            t_written <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                res       <= res_d;
                res_hi    <= res_hi_d;
                t         <= t_d;
                t_written <= tw_d;
            end
        end
    end

    iter_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (opc == OP_DIVU),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random ops vs a reference model.
// Latency: checks exact accept-to-out_valid cycle counts.
// Backpressure: exercises out_ready hold-off and ignored out_ready while busy.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic         t_written;
    logic         t;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_hi    (res_hi),
        .t_written (t_written),
        .t         (t)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the op definitions.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic [W-1:0] rh,
                         output logic ft, output logic ftw, output int lat);
        longint ux  = longint'(x);
        longint uy  = longint'(y);
        longint mod = longint'(1) << W;
        longint sx  = x[W-1] ? ux - mod : ux;
        longint sy  = y[W-1] ? uy - mod : uy;
        longint p;
        r = '0; rh = '0; ft = 1'b0; ftw = 1'b0; lat = 1;
        case (o)
            OP_ADD:  r = W'((ux + uy) % mod);
            OP_SUB:  r = W'((ux - uy + mod) % mod);
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOT:  r = W'(mod - 1 - ux);
            OP_NEG:  r = W'((mod - uy) % mod);
            OP_SLL:  r = (uy >= W) ? '0 : W'((ux << uy) % mod);
            OP_SRL:  r = (uy >= W) ? '0 : W'(ux >> uy);
            OP_SRA:  r = (uy >= W) ? (x[W-1] ? '1 : '0) : W'(sx >>> uy);
            OP_SLT:  begin ftw = 1'b1; ft = (sx < sy); end
            OP_SLTU: begin ftw = 1'b1; ft = (ux < uy); end
            OP_CMP:  begin ftw = 1'b1; ft = (ux != uy); end
            OP_MULTU: begin
                p = ux * uy;
                r = W'(p % mod); rh = W'(p / mod); lat = W + 1;
            end
            OP_DIVU: begin
                if (uy == 0) begin r = '1; rh = x; end
                else begin r = W'(ux / uy); rh = W'(ux % uy); lat = W + 1; end
            end
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold);
        logic [W-1:0] er, erh;
        logic         et, etw;
        int           elat, lat;
        logic         bad;
        model(o, x, y, er, erh, et, etw, elat);
        in_valid = 1'b1; op = o; a = x; b = y;
        check("accept_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 1; bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) bad = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            a = W'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check("busy_rdy_low", bad, 0);
        check("latency", lat, elat);
        check("res", res, er);
        check("res_hi", res_hi, erh);
        check("t", t, et);
        check("t_written", t_written, etw);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_vld_rdy", {out_valid, in_ready}, 2'b10);
            check("hold_res", {res_hi, res, t_written, t}, {erh, er, etw, et});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back_idle", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;
        logic         bad;
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {out_valid, in_ready}, 2'b01);
        check("rst_regs", {res_hi, res, t_written, t}, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rdy", in_ready, 1);

        // Directed corner cases
        run(OP_ADD,   16'hFFFF, 16'h0002, 0);
        run(OP_SRA,   16'h8000, 16'd20,   0);
        run(OP_SRL,   16'h8000, 16'd20,   0);
        run(OP_SRA,   16'h8000, 16'd15,   0);
        run(OP_SLL,   16'h0001, 16'd15,   0);
        run(OP_MULTU, 16'hFFFF, 16'hFFFF, 1);
        run(OP_DIVU,  16'd100,  16'd7,    0);
        run(OP_DIVU,  16'h1234, 16'h0000, 0);
        run(OP_SLT,   16'hFFFF, 16'h0001, 5);
        run(OP_CMP,   16'h5555, 16'h5555, 0);
        run(4'hF,     16'hABCD, 16'h1234, 0);

        // Reset in BUSY cycle 8 of a multiply
        in_valid = 1'b1; op = OP_MULTU; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy_rdy", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", {out_valid, in_ready}, 2'b01);
        check("abort_regs", {res_hi, res, t_written, t}, '0);
        bad = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad = 1'b1;
        end
        check("abort_no_result", bad, 0);
        run(OP_ADD, 16'h1000, 16'h0234, 0);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 24)) : W'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run(ro, ra, rb, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal: 8, 16, 32).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have port op, input, 4 bits: operation code, with encodings from the shared package.
REQ-008 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is held.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have ports res and res_hi, outputs, WIDTH bits each: res is the primary result; res_hi is the product high half or the remainder.
REQ-012 The block SHALL have ports t_written and t, outputs, 1 bit each: t_written marks a T-flag update; t is the flag value.

Function
REQ-013 The block SHALL support these ops: ADD, SUB, AND, OR, XOR, NOT(a), NEG(b), SLL, SRL, SRA, SLT, SLTU, CMP(t=a!=b), MULTU, DIVU.
REQ-014 The block SHALL keep a three-state FSM:
- IDLE: in_ready=1.
- BUSY: multicycle op in progress.
- DONE: out_valid=1.
REQ-015 An operation SHALL be accepted only when in_valid and in_ready are both 1; op, a and b are captured on that edge.
REQ-016 The block SHALL perform single-cycle ops as IDLE->DONE, with the result registered one cycle after acceptance.
REQ-017 MULTU SHALL be unsigned shift-add over exactly WIDTH BUSY cycles: {res_hi,res} = a*b; out_valid rises WIDTH+1 cycles after acceptance.
REQ-018 DIVU SHALL be unsigned restoring division over exactly WIDTH BUSY cycles: res=quotient, res_hi=remainder; out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 DIVU with b==0 SHALL skip BUSY and go IDLE->DONE in 1 cycle, with res=all ones and res_hi=a.
REQ-020 For single-cycle ops, the block SHALL drive res_hi=0.
REQ-021 Shift amount SHALL be b[SHW-1:0] when b<WIDTH.
REQ-022 When b>=WIDTH: SLL/SRL SHALL give 0, and SRA SHALL give all sign bits of a.
REQ-023 ADD, SUB and NEG SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-024 For SLT/SLTU/CMP, the block SHALL set t_written=1, set t, and drive res=0.
REQ-025 For all other ops, the block SHALL drive t_written=0 and t=0.
REQ-026 In DONE, all outputs SHALL hold stable until out_valid and out_ready are both 1.
REQ-027 On that handshake edge the FSM SHALL go to IDLE; in_ready stays 0 during DONE (no same-cycle accept).
REQ-028 In BUSY, in_ready SHALL be 0; input changes and out_ready SHALL be ignored.
REQ-029 An undefined op SHALL complete in 1 cycle with res=0, res_hi=0, t_written=0.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the cycle counter SHALL clear.
REQ-031 On that edge the block SHALL clear res, res_hi, t and t_written.
REQ-032 After reset, out_valid SHALL be 0 and in_ready SHALL be 1 on the following cycle.
REQ-033 Reset SHALL take priority over any accept or handshake in the same cycle.
REQ-034 A reset during BUSY SHALL abort the operation, and no result is produced.

Structure
REQ-035 Op encodings, the FSM state enum and the default WIDTH SHALL live in shared package alu_pkg.
REQ-036 The iterative multiply/divide datapath (counter, partial product or remainder, and its shift register) SHALL be one sub-module, iter_muldiv, with start/done handshake.
REQ-037 seq_alu SHALL hold the FSM, single-cycle logic and output registers.

Verification
REQ-038 The bench SHALL cover ADD, WIDTH=16: a=0xFFFF, b=0x0002 -> res=0x0001 one cycle after accept; t_written=0.
REQ-039 The bench SHALL cover SRA, WIDTH=16: a=0x8000, b=20 -> res=0xFFFF; and SRL with b=20 -> res=0x0000.
REQ-040 The bench SHALL cover MULTU, WIDTH=16: a=0xFFFF, b=0xFFFF -> res_hi=0xFFFE, res=0x0001; out_valid exactly 17 cycles after accept; in_ready=0 throughout.
REQ-041 The bench SHALL cover DIVU, WIDTH=16:
- a=100, b=7 -> res=14, res_hi=2 after 17 cycles.
- b=0 -> res=0xFFFF, res_hi=a after 1 cycle.
REQ-042 The bench SHALL cover SLT back-pressure: a=0xFFFF, b=0x0001 -> t_written=1, t=1; with out_ready=0 for 5 cycles, outputs hold stable and in_ready=0.
REQ-043 The bench SHALL cover reset mid-MULTU: assert rst at BUSY cycle 8 -> next cycle in_ready=1, out_valid=0, res=0; a new ADD completes normally.
